// File: rtl/pac_pkg.sv
// Shared definitions for the Pacman design: game state encoding and coordinate widths.
package pac_pkg;

  // Game-level state; this encoding is also decoded by Display and KeyControl.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  localparam int unsigned X_W = 10;
  localparam int unsigned Y_W = 10;

endpackage

// File: rtl/pac_collide.sv
// Combinational proximity test between two sprites: hit when both axis
// distances are strictly less than HIT_DIST pixels.
module pac_collide
  import pac_pkg::*;
#(
  parameter int unsigned HIT_DIST = 12
) (
  input  logic [X_W-1:0] a_x_i,
  input  logic [Y_W-1:0] a_y_i,
  input  logic [X_W-1:0] b_x_i,
  input  logic [Y_W-1:0] b_y_i,
  output logic           hit_o
);

  logic [X_W-1:0] dx;
  logic [Y_W-1:0] dy;

  // Unsigned magnitude of the per-axis difference, then threshold compare.
  always_comb begin
    dx    = (a_x_i >= b_x_i) ? (a_x_i - b_x_i) : (b_x_i - a_x_i);
    dy    = (a_y_i >= b_y_i) ? (a_y_i - b_y_i) : (b_y_i - a_y_i);
    hit_o = ({1'b0, dx} < (X_W+1)'(HIT_DIST)) && ({1'b0, dy} < (Y_W+1)'(HIT_DIST));
  end

endmodule

// File: rtl/pac_game_ctrl.sv
// Central game sequencer: IDLE/PLAY/DYING/OVER state machine, frame-gated
// movement strobe, mover reload pulse, collision handling, lives/score/pellets.
module pac_game_ctrl
  import pac_pkg::*;
#(
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned HIT_DIST      = 12,
  parameter int unsigned DEATH_TICKS   = 60,
  parameter int unsigned PELLETS_TOTAL = 240,
  parameter int unsigned PELLET_PTS    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic [9:0]  pac_x,
  input  logic [9:0]  pac_y,
  input  logic [9:0]  ghost_x,
  input  logic [8:0]  ghost_y,
  input  logic        pellet_eaten,
  output logic [1:0]  state,
  output logic        move_en,
  output logic        reload,
  output logic        won,
  output logic [2:0]  lives,
  output logic [15:0] score
);

  game_state_t state_q;
  logic [2:0]  lives_q;
  logic [15:0] score_q;
  logic [15:0] pellets_q;
  logic [7:0]  death_q;
  logic        move_en_q;
  logic        reload_q;
  logic        won_q;

  logic        hit;
  logic [16:0] score_sum;
  logic [15:0] score_d;
  logic [16:0] pellets_d;
  logic        last_pellet;

  pac_collide #(.HIT_DIST(HIT_DIST)) u_collide (
    .a_x_i (pac_x),
    .a_y_i (pac_y),
    .b_x_i (ghost_x),
    .b_y_i ({1'b0, ghost_y}),
    .hit_o (hit)
  );

  // Saturating score increment and pellet-count win detection.
  always_comb begin
    score_sum   = {1'b0, score_q} + 17'(PELLET_PTS);
    score_d     = score_sum[16] ? '1 : score_sum[15:0];
    pellets_d   = {1'b0, pellets_q} + 17'd1;
    last_pellet = (pellets_d == 17'(PELLETS_TOTAL));
  end

  // Game state machine with registered strobes and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lives_q   <= 3'(LIVES_INIT);
      score_q   <= '0;
      pellets_q <= '0;
      death_q   <= '0;
      move_en_q <= 1'b0;
      reload_q  <= 1'b0;
      won_q     <= 1'b0;
    end else begin
      move_en_q <= 1'b0;
      reload_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state_q   <= ST_PLAY;
            reload_q  <= 1'b1;
            lives_q   <= 3'(LIVES_INIT);
            score_q   <= '0;
            pellets_q <= '0;
            won_q     <= 1'b0;
          end
        end
        ST_PLAY: begin
          move_en_q <= tick;
          if (pellet_eaten) begin
            score_q   <= score_d;
            pellets_q <= pellets_d[15:0];
          end
          // A winning pellet takes precedence over a same-edge collision.
          if (pellet_eaten && last_pellet) begin
            state_q <= ST_OVER;
            won_q   <= 1'b1;
          end else if (tick && hit) begin
            state_q <= ST_DYING;
            lives_q <= lives_q - 3'd1;
            death_q <= 8'(DEATH_TICKS);
          end
        end
        ST_DYING: begin
          if (tick) begin
            death_q <= death_q - 8'd1;
            if (death_q == 8'd1) begin
              if (lives_q == 3'd0) begin
                state_q <= ST_OVER;
                won_q   <= 1'b0;
              end else begin
                state_q  <= ST_PLAY;
                reload_q <= 1'b1;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state   = state_q;
  assign move_en = move_en_q;
  assign reload  = reload_q;
  assign won     = won_q;
  assign lives   = lives_q;
  assign score   = score_q;

endmodule

// File: tb/tb_pac_game_ctrl.sv
// Directed self-checking bench for pac_game_ctrl.
module tb_pac_game_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  pac_x = 10'd100;
  logic [9:0]  pac_y = 10'd100;
  logic [9:0]  ghost_x = 10'd400;
  logic [8:0]  ghost_y = 9'd300;
  logic        pellet_eaten = 1'b0;
  logic [1:0]  state;
  logic        move_en;
  logic        reload;
  logic        won;
  logic [2:0]  lives;
  logic [15:0] score;

  // Second instance used only for score saturation.
  logic        s_start = 1'b0;
  logic        s_pellet = 1'b0;
  logic        s_tick = 1'b0;
  logic [1:0]  s_state;
  logic        s_move_en;
  logic        s_reload;
  logic        s_won;
  logic [2:0]  s_lives;
  logic [15:0] s_score;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pac_game_ctrl #(.PELLETS_TOTAL(4)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .pellet_eaten(pellet_eaten),
    .state(state), .move_en(move_en), .reload(reload), .won(won),
    .lives(lives), .score(score)
  );

  pac_game_ctrl #(.PELLETS_TOTAL(65535), .PELLET_PTS(10)) dut_sat (
    .clk(clk), .rst(rst), .tick(s_tick), .start(s_start),
    .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .pellet_eaten(s_pellet),
    .state(s_state), .move_en(s_move_en), .reload(s_reload), .won(s_won),
    .lives(s_lives), .score(s_score)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    repeat (10) cyc();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (lives !== 3'd3) begin failures++; $display("FAIL reset_lives got=%0d exp=3", lives); end
    checks++; if (score !== 16'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", score); end
    checks++; if (move_en !== 1'b0) begin failures++; $display("FAIL reset_move_en got=%b exp=0", move_en); end
    checks++; if (reload !== 1'b0) begin failures++; $display("FAIL reset_reload got=%b exp=0", reload); end
    checks++; if (won !== 1'b0) begin failures++; $display("FAIL reset_won got=%b exp=0", won); end
  endtask

  task automatic test_start_and_move();
    int pulses;
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL start_state got=%0d exp=1", state); end
    checks++; if (reload !== 1'b1) begin failures++; $display("FAIL start_reload got=%b exp=1", reload); end
    cyc();
    checks++; if (reload !== 1'b0) begin failures++; $display("FAIL start_reload_len got=%b exp=0", reload); end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1;
      checks++; if (move_en !== 1'b0) begin failures++; $display("FAIL move_en_early i=%0d got=%b exp=0", i, move_en); end
      cyc();
      tick = 1'b0;
      if (move_en === 1'b1) pulses++;
      checks++; if (reload !== 1'b0) begin failures++; $display("FAIL move_reload_overlap i=%0d got=%b exp=0", i, reload); end
      cyc();
      checks++; if (move_en !== 1'b0) begin failures++; $display("FAIL move_en_width i=%0d got=%b exp=0", i, move_en); end
    end
    checks++; if (pulses !== 5) begin failures++; $display("FAIL move_en_count got=%0d exp=5", pulses); end
  endtask

  // Collide on a tick, then run out the death timer; expects a return to PLAY
  // or OVER depending on exp_lives.
  task automatic die(input logic [2:0] exp_lives, input string tag);
    int stuck;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    ghost_x = 10'd400;
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL %s_dying got=%0d exp=2", tag, state); end
    checks++; if (lives !== exp_lives) begin failures++; $display("FAIL %s_lives got=%0d exp=%0d", tag, lives, exp_lives); end
    start = 1'b1;  // ignored while dying
    stuck = 0;
    for (int i = 0; i < 59; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      if (state !== 2'd2 || move_en !== 1'b0 || reload !== 1'b0) stuck++;
      cyc();
    end
    start = 1'b0;
    checks++; if (stuck !== 0) begin failures++; $display("FAIL %s_dying_hold bad_cycles=%0d exp=0", tag, stuck); end
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    checks++; if (move_en !== 1'b0) begin failures++; $display("FAIL %s_exit_move_en got=%b exp=0", tag, move_en); end
    if (exp_lives != 3'd0) begin
      checks++; if (state !== 2'd1) begin failures++; $display("FAIL %s_respawn got=%0d exp=1", tag, state); end
      checks++; if (reload !== 1'b1) begin failures++; $display("FAIL %s_reload got=%b exp=1", tag, reload); end
    end else begin
      checks++; if (state !== 2'd3) begin failures++; $display("FAIL %s_over got=%0d exp=3", tag, state); end
      checks++; if (won !== 1'b0) begin failures++; $display("FAIL %s_won got=%b exp=0", tag, won); end
      checks++; if (reload !== 1'b0) begin failures++; $display("FAIL %s_no_reload got=%b exp=0", tag, reload); end
    end
    cyc();
    checks++; if (reload !== 1'b0) begin failures++; $display("FAIL %s_reload_len got=%b exp=0", tag, reload); end
  endtask

  task automatic test_collision();
    pac_x = 10'd100; pac_y = 10'd100;
    // Overlapping position without a tick is not evaluated.
    ghost_x = 10'd108; ghost_y = 9'd90;
    cyc();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL collide_no_tick got=%0d exp=1", state); end
    die(3'd2, "coll1");
    // dx = 12 is exactly the threshold: no hit.
    ghost_x = 10'd112; ghost_y = 9'd100;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL dx12_state got=%0d exp=1", state); end
    checks++; if (lives !== 3'd2) begin failures++; $display("FAIL dx12_lives got=%0d exp=2", lives); end
    // dy = 12 (ghost below) is also no hit.
    ghost_x = 10'd100; ghost_y = 9'd112;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL dy12_state got=%0d exp=1", state); end
    cyc();
  endtask

  task automatic test_game_over();
    start = 1'b1;  // start ignored in PLAY
    ghost_x = 10'd89; ghost_y = 9'd100;  // dx = 11: hit
    die(3'd1, "coll2");
    start = 1'b0;
    ghost_x = 10'd100; ghost_y = 9'd111;  // dy = 11: hit
    die(3'd0, "coll3");
    checks++; if (lives !== 3'd0) begin failures++; $display("FAIL over_lives got=%0d exp=0", lives); end
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL restart_state got=%0d exp=1", state); end
    checks++; if (lives !== 3'd3) begin failures++; $display("FAIL restart_lives got=%0d exp=3", lives); end
    checks++; if (score !== 16'd0) begin failures++; $display("FAIL restart_score got=%0d exp=0", score); end
    checks++; if (reload !== 1'b1) begin failures++; $display("FAIL restart_reload got=%b exp=1", reload); end
    cyc();
  endtask

  task automatic test_pellets();
    ghost_x = 10'd400; ghost_y = 9'd300;
    for (int i = 0; i < 3; i++) begin
      pellet_eaten = 1'b1;
      cyc();
      pellet_eaten = 1'b0;
      cyc();
    end
    checks++; if (score !== 16'd30) begin failures++; $display("FAIL pellet3_score got=%0d exp=30", score); end
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL pellet3_state got=%0d exp=1", state); end
    // Last pellet coincides with a colliding tick: win wins.
    ghost_x = 10'd105; ghost_y = 9'd95;
    pellet_eaten = 1'b1; tick = 1'b1;
    cyc();
    pellet_eaten = 1'b0; tick = 1'b0;
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL win_state got=%0d exp=3", state); end
    checks++; if (won !== 1'b1) begin failures++; $display("FAIL win_won got=%b exp=1", won); end
    checks++; if (lives !== 3'd3) begin failures++; $display("FAIL win_lives got=%0d exp=3", lives); end
    checks++; if (score !== 16'd40) begin failures++; $display("FAIL win_score got=%0d exp=40", score); end
    // Pellets and ticks in OVER are ignored.
    pellet_eaten = 1'b1; tick = 1'b1;
    cyc(); cyc();
    pellet_eaten = 1'b0; tick = 1'b0;
    checks++; if (score !== 16'd40) begin failures++; $display("FAIL over_score got=%0d exp=40", score); end
    checks++; if (state !== 2'd3 || won !== 1'b1) begin failures++; $display("FAIL over_hold state=%0d won=%b exp=3/1", state, won); end
    // Restart, then four back-to-back pellets.
    ghost_x = 10'd400; ghost_y = 9'd300;
    start = 1'b1;
    cyc();
    start = 1'b0;
    pellet_eaten = 1'b1;
    repeat (4) cyc();
    pellet_eaten = 1'b0;
    checks++; if (score !== 16'd40) begin failures++; $display("FAIL b2b_score got=%0d exp=40", score); end
    checks++; if (state !== 2'd3 || won !== 1'b1) begin failures++; $display("FAIL b2b_win state=%0d won=%b exp=3/1", state, won); end
  endtask

  task automatic test_saturation();
    s_start = 1'b1;
    cyc();
    s_start = 1'b0;
    s_pellet = 1'b1;
    repeat (6553) cyc();
    s_pellet = 1'b0;
    checks++; if (s_score !== 16'd65530) begin failures++; $display("FAIL sat_pre got=%0d exp=65530", s_score); end
    s_pellet = 1'b1;
    cyc();
    checks++; if (s_score !== 16'd65535) begin failures++; $display("FAIL sat_clip got=%0d exp=65535", s_score); end
    cyc();
    s_pellet = 1'b0;
    checks++; if (s_score !== 16'd65535) begin failures++; $display("FAIL sat_hold got=%0d exp=65535", s_score); end
    checks++; if (s_state !== 2'd1) begin failures++; $display("FAIL sat_state got=%0d exp=1", s_state); end
  endtask

  task automatic test_reset_mid_dying();
    int bad;
    start = 1'b1;
    cyc();
    start = 1'b0;
    ghost_x = 10'd100; ghost_y = 9'd100;
    tick = 1'b1;
    cyc();
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL rd_enter got=%0d exp=2", state); end
    cyc(); cyc();  // a few death ticks
    tick = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    ghost_x = 10'd400; ghost_y = 9'd300;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL rd_state got=%0d exp=0", state); end
    checks++; if (lives !== 3'd3) begin failures++; $display("FAIL rd_lives got=%0d exp=3", lives); end
    bad = 0;
    for (int i = 0; i < 70; i++) begin
      if (reload !== 1'b0 || state !== 2'd0) bad++;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL rd_quiet bad_cycles=%0d exp=0", bad); end
  endtask

  initial begin
    #1;
    test_reset();
    test_saturation();
    test_start_and_move();
    test_collision();
    test_game_over();
    test_pellets();
    test_reset_mid_dying();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
